// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared, external combinational shifter.
// Each accepted request spends one cycle presenting operands (SHIFT) and then
// holds its result on the response channel (RESP) until the consumer takes it.
// Optional feature: define SHIFT_ARB_RR_EN for round-robin arbitration;
// the default build uses fixed priority with requester 0 highest.
module shift_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [3:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*AMT_W-1:0]    req_amt,
  output logic [1:0]            sh_op,
  output logic [DATA_W-1:0]     sh_a,
  output logic [AMT_W-1:0]      sh_b,
  input  logic [DATA_W-1:0]     sh_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_win;
  logic                w_accept;
  logic [1:0]          w_ready;
  logic [1:0]          w_op;
  logic [DATA_W-1:0]   w_a;
  logic [AMT_W-1:0]    w_amt;

  logic [1:0]          r_sh_op;
  logic [DATA_W-1:0]   r_sh_a;
  logic [AMT_W-1:0]    r_sh_b;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_id;

`ifdef SHIFT_ARB_RR_EN
  logic r_ptr;

  // Round-robin winner: the pointed-to requester if valid, otherwise the other one
  always_comb begin
    w_win = r_ptr;
    if (!req_valid[r_ptr]) w_win = ~r_ptr;
  end

  // Pointer moves away from the requester just served
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_ptr <= 1'b0;
    else if (w_accept) r_ptr <= ~w_win;
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid
  always_comb begin
    w_win = ~req_valid[0];
  end
`endif

  // Winner's payload
  always_comb begin
    w_op  = w_win ? req_op[3:2]                : req_op[1:0];
    w_a   = w_win ? req_a[2*DATA_W-1:DATA_W]   : req_a[DATA_W-1:0];
    w_amt = w_win ? req_amt[2*AMT_W-1:AMT_W]   : req_amt[AMT_W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state and grant; grants only in IDLE and never while reset is held
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ready  = 2'b00;
    case (r_state)
      IDLE: begin
        if ((|req_valid) && reset_n) begin
          w_ready  = w_win ? 2'b10 : 2'b01;
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: w_next = RESP;
      RESP: begin
        if (r_rsp_valid && rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Shifter operands load on accept and hold otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_op  <= 2'b00;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_rsp_id <= 1'b0;
    end else if (w_accept) begin
      r_sh_op  <= w_op;
      r_sh_a   <= w_a;
      r_sh_b   <= w_amt;
      r_rsp_id <= w_win;
    end
  end

  // Response capture at the end of SHIFT, release on handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (r_state == SHIFT) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= sh_out;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = w_ready;
  assign sh_op     = r_sh_op;
  assign sh_a      = r_sh_a;
  assign sh_b      = r_sh_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter; models the external shifter and checks
// hand-computed results, arbitration order, backpressure and reset behaviour.
module tb_shift_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  logic                clk;
  logic                reset_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [3:0]          req_op;
  logic [2*DATA_W-1:0] req_a;
  logic [2*AMT_W-1:0]  req_amt;
  logic [1:0]          sh_op;
  logic [DATA_W-1:0]   sh_a;
  logic [AMT_W-1:0]    sh_b;
  logic [DATA_W-1:0]   sh_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_id;
  logic                busy;

  int n_chk;
  int n_fail;

  shift_arbiter #(.DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_amt(req_amt),
    .sh_op(sh_op), .sh_a(sh_a), .sh_b(sh_b), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational shifter
  always_comb begin
    case (sh_op)
      2'b00:   sh_out = sh_a << sh_b;
      2'b01:   sh_out = sh_a >> sh_b;
      2'b11:   sh_out = DATA_W'($signed(sh_a) >>> sh_b);
      default: sh_out = sh_a;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] amt);
    if (id == 0) begin
      req_op[1:0] = op; req_a[31:0] = a; req_amt[4:0] = amt;
    end else begin
      req_op[3:2] = op; req_a[63:32] = a; req_amt[9:5] = amt;
    end
  endtask

  // One full transaction with rsp_ready held high; called #1 after a posedge in IDLE
  task automatic run_one(input string tag, input int id, input logic [1:0] op,
                         input logic [31:0] a, input logic [4:0] amt, input logic [31:0] exp);
    set_req(id, op, a, amt);
    req_valid = (id == 0) ? 2'b01 : 2'b10;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), (id == 0) ? 64'h1 : 64'h2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk({tag, "_sh_op"}, 64'(sh_op), 64'(op));
    chk({tag, "_sh_a"}, 64'(sh_a), 64'(a));
    chk({tag, "_sh_b"}, 64'(sh_b), 64'(amt));
    chk({tag, "_busy1"}, 64'(busy), 64'h1);
    chk({tag, "_vld_early"}, 64'(rsp_valid), 64'h0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, 64'(rsp_valid), 64'h1);
    chk({tag, "_data"}, 64'(rsp_data), 64'(exp));
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    @(posedge clk); #1;
    chk({tag, "_vld_done"}, 64'(rsp_valid), 64'h0);
    chk({tag, "_idle"}, 64'(busy), 64'h0);
  endtask

  initial begin
    int ids[4];
    int at[4];
    int n;
    int cyc;
    int pulses;
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 2'b11; req_op = '0; req_a = '0; req_amt = '0;
    #2;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_vld", 64'(rsp_valid), 64'h0);
    chk("rst_data", 64'(rsp_data), 64'h0);
    chk("rst_sh_a", 64'(sh_a), 64'h0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_one("sll", 0, 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
    run_one("sra", 1, 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_one("srl", 1, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run_one("pass", 0, 2'b10, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF);
    run_one("amt0", 1, 2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678);

    // Contention: both requesters valid continuously
    set_req(0, 2'b00, 32'h1, 5'd1);
    set_req(1, 2'b00, 32'h1, 5'd2);
    req_valid = 2'b11;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin
        ids[n] = int'(rsp_id);
        at[n] = cyc;
        chk("cont_data", 64'(rsp_data), rsp_id ? 64'h4 : 64'h2);
        n++;
      end
    end
    req_valid = 2'b00;
    chk("cont_count", 64'(n), 64'h4);
    for (int k = 0; k < n; k++) begin
`ifdef SHIFT_ARB_RR_EN
      chk("cont_id", 64'(ids[k]), 64'(k % 2));
`else
      chk("cont_id", 64'(ids[k]), 64'h0);
`endif
      if (k > 0) chk("cont_gap", 64'(at[k] - at[k-1]), 64'h3);
    end
    @(posedge clk); #1;
    chk("cont_idle", 64'(busy), 64'h0);

    // Backpressure with requester 1 held valid
    rsp_ready = 1'b0;
    set_req(1, 2'b00, 32'h3, 5'd1);
    req_valid = 2'b10;
    #1;
    chk("bp_ready", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    chk("bp_shift_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld", 64'(rsp_valid), 64'h1);
      chk("bp_data", 64'(rsp_data), 64'h6);
      chk("bp_id", 64'(rsp_id), 64'h1);
      chk("bp_ready_low", 64'(req_ready), 64'h0);
      chk("bp_busy", 64'(busy), 64'h1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    chk("bp_vld_clr", 64'(rsp_valid), 64'h0);
    chk("bp_reaccept", 64'(req_ready), 64'h2);
    req_valid = 2'b00;
    #1;
    chk("withdraw_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    chk("withdraw_idle", 64'(busy), 64'h0);

    // Reset while in SHIFT
    set_req(0, 2'b00, 32'h5, 5'd3);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("rs_busy", 64'(busy), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("rs_busy0", 64'(busy), 64'h0);
    chk("rs_vld", 64'(rsp_valid), 64'h0);
    chk("rs_data", 64'(rsp_data), 64'h0);
    chk("rs_id", 64'(rsp_id), 64'h0);
    chk("rs_sh_op", 64'(sh_op), 64'h0);
    chk("rs_sh_a", 64'(sh_a), 64'h0);
    chk("rs_sh_b", 64'(sh_b), 64'h0);
    req_valid = 2'b01;
    #1;
    chk("rs_ready", 64'(req_ready), 64'h0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    chk("rs_no_pulse", 64'(pulses), 64'h0);
    run_one("post_rst", 0, 2'b01, 32'h0000_0100, 5'd4, 32'h0000_0010);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: operand and result width in bits.
REQ-002 The block SHALL have parameter AMT_W, default 5: shift-amount width in bits, equal to log2(DATA_W).
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req_valid[i], input, 1 each, i=0,1: requester i presents a shift request.
REQ-006 The block SHALL have ports req_ready[i], output, 1 each: request i is accepted this cycle.
REQ-007 The block SHALL have ports req_op[i], input, 2 each: shift opcode (00 SLL, 01 SRL, 11 SRA, 10 pass-through).
REQ-008 The block SHALL have ports req_a[i], input, DATA_W each (signed), and req_amt[i], input, AMT_W each: operand and shift amount.
REQ-009 The block SHALL have ports sh_op, output, 2; sh_a, output, DATA_W; sh_b, output, AMT_W: registered operands to the shared combinational shifter.
REQ-010 The block SHALL have port sh_out, input, DATA_W: the shifter result.
REQ-011 The block SHALL have ports rsp_valid, output, 1; rsp_ready, input, 1; rsp_data, output, DATA_W; rsp_id, output, 1: the response channel, with rsp_id giving the requester index.
REQ-012 The block SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have three states, IDLE, SHIFT and RESP; IDLE->SHIFT on an accept, SHIFT->RESP unconditionally, RESP->IDLE when rsp_valid and rsp_ready are both high.
REQ-014 req_ready SHALL be combinational, asserted only in IDLE, only for the arbitration winner among asserted req_valid, and never for both requesters in the same cycle.
REQ-015 An accept SHALL occur when req_valid[i] and req_ready[i] are both high; requesters hold valid and payload stable until accepted.
REQ-016 On an accept in cycle N, sh_op/sh_a/sh_b SHALL take the winner's op/a/amt and be valid throughout cycle N+1 (SHIFT).
REQ-017 At the end of SHIFT, sh_out SHALL be captured into rsp_data, and rsp_valid SHALL be high from cycle N+2.
REQ-018 rsp_data, rsp_id and rsp_valid SHALL hold stable while rsp_valid is high and rsp_ready is low, and no new accept SHALL occur during that time.
REQ-019 With rsp_ready high in the first RESP cycle, a new accept SHALL be possible in the following cycle, giving a peak throughput of 1 request per 3 cycles.
REQ-020 sh_op/sh_a/sh_b SHALL hold their last values outside SHIFT.
REQ-021 A request with req_amt=0 or op=10 SHALL complete normally, with rsp_data equal to req_a.
REQ-022 A requester deasserting req_valid before acceptance SHALL be ignored; arbitration is re-evaluated every IDLE cycle.

Reset
REQ-023 Asserting reset_n low SHALL immediately force state=IDLE, rsp_valid=0, busy=0, rsp_data=0, rsp_id=0, sh_op=00, sh_a=0, sh_b=0, and priority pointer=requester 0.
REQ-024 A reset asserted mid-transaction (SHIFT or RESP) SHALL discard that transaction, with no response ever issued for it.
REQ-025 req_ready SHALL be low while reset_n is low.

Configuration
REQ-026 With macro SHIFT_ARB_RR_EN defined, arbitration SHALL be round-robin: the pointer moves to the other requester after each accept, so with both requesters valid continuously, grants alternate 0,1,0,1.
REQ-027 Without SHIFT_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 always wins when valid, and no pointer register exists.

Verification
REQ-028 Single request: req0 valid, op=00, a=0x0000_0001, amt=4 -> req_ready[0] in cycle 0, sh_* driven in cycle 1, rsp_valid in cycle 2 with rsp_data=0x0000_0010 and rsp_id=0.
REQ-029 SRA: req1, op=11, a=0x8000_0000, amt=31 -> rsp_data=0xFFFF_FFFF, rsp_id=1; the same request with op=01 -> rsp_data=0x0000_0001.
REQ-030 Contention, both valid continuously for 4 transactions with rsp_ready=1 -> with SHIFT_ARB_RR_EN, rsp_id sequence 0,1,0,1 at a 3-cycle spacing; without it, 0,0,0,0.
REQ-031 Backpressure: rsp_ready low for 5 cycles with req1 valid -> rsp_valid/rsp_data held stable, req_ready all low and busy=1 throughout; accept one cycle after the handshake.
REQ-032 Reset in SHIFT: assert reset_n low in cycle 1 of a transaction -> all outputs take their reset values immediately, and no rsp_valid pulse occurs after release.
